round_controller: RTL

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/tug_pkg.sv | 14 +
 rtl/hold_counter.sv | 34 +++
 rtl/round_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tug_pkg.sv
// Shared types and default constants for the tug-of-war round controller.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    HOLD    = 2'd1,
    RESTART = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned WIN_SCORE_DEF   = 7;
  localparam int unsigned HOLD_CYCLES_DEF = 4;

endpackage

// File: rtl/hold_counter.sv
// 8-bit down-counter timing the frozen-field interval after a round win.
module hold_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       count,
  output logic       done
);

  logic [7:0] cnt_d, cnt_q;

  // Load wins over count; counting stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 8'd0);

endmodule

// File: rtl/round_controller.sv
// Round/match controller: scores round wins, freezes the field, then re-centers it.
module round_controller
  import tug_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       leftEdge,
  input  logic       rightEdge,
  output logic       roundWin,
  output logic       fieldReset,
  output logic [2:0] leftScore,
  output logic [2:0] rightScore,
  output logic       matchOver,
  output logic       winner
);

  localparam logic [2:0] WinScore = 3'(WIN_SCORE);
  // Counter is loaded with one less because the entry cycle already counts.
  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

  state_t     state_d, state_q;
  logic [2:0] left_score_d, left_score_q;
  logic [2:0] right_score_d, right_score_q;
  logic       round_win_d, round_win_q;
  logic       field_reset_d, field_reset_q;
  logic       match_over_d, match_over_q;
  logic       winner_d, winner_q;

  logic hold_load, hold_count, hold_done;
  logic left_win, right_win;

  // A single key only checks its own edge; both keys together cancel out.
  assign left_win  = L && !R && leftEdge && (left_score_q < WinScore);
  assign right_win = R && !L && rightEdge && (right_score_q < WinScore);

  hold_counter u_hold_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (HoldLoad),
    .count    (hold_count),
    .done     (hold_done)
  );

  // Next state, next scores and next registered outputs.
  always_comb begin
    state_d       = state_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    round_win_d   = 1'b0;
    field_reset_d = 1'b0;
    match_over_d  = match_over_q;
    winner_d      = winner_q;
    hold_load     = 1'b0;
    hold_count    = 1'b0;

    case (state_q)
      PLAY: begin
        if (left_win) begin
          left_score_d = left_score_q + 3'd1;
          round_win_d  = 1'b1;
          if (left_score_d == WinScore) begin
            state_d      = DONE;
            match_over_d = 1'b1;
            winner_d     = 1'b0;
          end else begin
            state_d   = HOLD;
            hold_load = 1'b1;
          end
        end else if (right_win) begin
          right_score_d = right_score_q + 3'd1;
          round_win_d   = 1'b1;
          if (right_score_d == WinScore) begin
            state_d      = DONE;
            match_over_d = 1'b1;
            winner_d     = 1'b1;
          end else begin
            state_d   = HOLD;
            hold_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_done) begin
          state_d       = RESTART;
          field_reset_d = 1'b1;
        end else begin
          round_win_d = 1'b1;
          hold_count  = 1'b1;
        end
      end
      RESTART: begin
        state_d = PLAY;
      end
      DONE: begin
        round_win_d = 1'b1;
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PLAY;
      left_score_q  <= 3'd0;
      right_score_q <= 3'd0;
      round_win_q   <= 1'b0;
      field_reset_q <= 1'b0;
      match_over_q  <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      round_win_q   <= round_win_d;
      field_reset_q <= field_reset_d;
      match_over_q  <= match_over_d;
      winner_q      <= winner_d;
    end
  end

  assign roundWin   = round_win_q;
  assign fieldReset = field_reset_q;
  assign leftScore  = left_score_q;
  assign rightScore = right_score_q;
  assign matchOver  = match_over_q;
  assign winner     = winner_q;

endmodule
